instr_queue: RTL and testbench
==============================

# instr_queue

Instruction buffer between `fetch` and decode. It accepts decoded-length instructions from `fetch`'s result port, stores them in a small FIFO, tags each one with its byte address, and presents them to decode with a valid/ready handshake. It also owns the fetch PC: it issues the reset PC and any redirect PC to `fetch`'s request port, and flushes stale instructions on redirect.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO entries; must be a power of 2, ≥2.
- `PTR_W`, 2 — log2(`DEPTH`).
- `RESET_PC`, `` `ADDRESS_WIDTH'h0 `` — first PC issued after reset.

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge.
- `reset`  in  1  — **asynchronous, active-low**; `reset`=0 clears all state immediately.
- `o_pc_valid`  out  1  — PC request to `fetch` (`fetch.i_valid`).
- `o_pc`  out  `` `ADDRESS_WIDTH `` — requested PC (`fetch.i_pc`).
- `i_pc_ready`  in  1  — `fetch.o_ready`; the PC is accepted when `o_pc_valid` && `i_pc_ready`.
- `i_fetch_valid`  in  1  — `fetch.o_res_valid`.
- `i_fetch_instr`  in  `` `MAX_INSTR_WIDTH `` — `fetch.o_instr`.
- `i_fetch_len`  in  4  — `fetch.o_instr_len`, in bytes.
- `o_fetch_ready`  out  1  — the queue accepts an instruction when `i_fetch_valid` && `o_fetch_ready`.
- `i_redirect_valid`  in  1  — one-cycle redirect strobe from the back end.
- `i_redirect_pc`  in  `` `ADDRESS_WIDTH `` — redirect target.
- `o_valid`  out  1  — the head entry is valid for decode.
- `o_instr`  out  `` `MAX_INSTR_WIDTH `` — head instruction.
- `o_instr_len`  out  4 — head instruction length.
- `o_pc`-tagged head address is driven on `o_instr_pc`  out  `` `ADDRESS_WIDTH `` — byte address of the head instruction.
- `i_ready`  in  1  — decode accepts the head when `o_valid` && `i_ready`.
- `o_len_err`  out  1  — sticky flag; set when a zero-length instruction is received.

## Operation
- The FSM has two states:
  - `S_REDIR`: `o_pc_valid`=1 and `o_pc`=`pend_pc`. On `i_pc_ready`, `next_pc` ← `pend_pc` and the state moves to `S_RUN`. In this state `o_fetch_ready`=1 and every incoming instruction is dropped without being written.
  - `S_RUN`: `o_pc_valid`=0. Instructions are enqueued normally.
- **Reset:** state=`S_REDIR`, `pend_pc`=`RESET_PC`, FIFO empty, `next_pc`=0, `o_len_err`=0.
- **Push:** occurs in `S_RUN` when `i_fetch_valid` && `o_fetch_ready`. The entry stored is {`i_fetch_instr`, `i_fetch_len`, `next_pc`}, and `next_pc` ← `next_pc` + `i_fetch_len`, which wraps modulo 2^`ADDRESS_WIDTH`.
- **Zero-length push:** if `i_fetch_len`=0 the entry is not written, `next_pc` is unchanged, and `o_len_err` is set to 1. `o_len_err` clears only on reset.
- **Flow control:** `o_fetch_ready` in `S_RUN` = (count < `DEPTH`). It depends only on registered state and never on `i_ready`, so a full queue does not accept a push in the same cycle as a pop.
- **Pop:** occurs when `o_valid` && `i_ready`; the read pointer advances. Push and pop in the same cycle leave count unchanged.
- **Redirect:** when `i_redirect_valid`=1 in any state, on that edge:
  - the FIFO is flushed (count=0, pointers=0);
  - `pend_pc` ← `i_redirect_pc` and state ← `S_REDIR`;
  - any push or pop that cycle is discarded.
  - A redirect arriving during `S_REDIR` replaces `pend_pc`; `o_pc` may change while `o_pc_valid` is held high.
- **Fetch contract:** after accepting a new PC, `fetch` returns no results for the old stream.

## Timing
- Output reset values: `o_pc_valid`=1, `o_pc`=`RESET_PC`, `o_fetch_ready`=1, `o_valid`=0, `o_instr`=0, `o_instr_len`=0, `o_instr_pc`=0, `o_len_err`=0.
- Enqueue to head: an instruction pushed at edge N is visible on `o_valid` after edge N (registered storage, no bypass), so the minimum latency is 1 cycle.
- Throughput: one push and one pop per cycle.
- Redirect: after the edge that samples `i_redirect_valid`, `o_valid`=0 and `o_pc_valid`=1.
- PC handoff: `S_REDIR`→`S_RUN` takes 1 cycle after the `i_pc_ready` handshake edge.
- Decode outputs (`o_instr`, `o_instr_len`, `o_instr_pc`) hold stable while `o_valid` && !`i_ready`.

## Structure
- The FIFO is a sub-module, `instr_fifo`:
  - parameterised on `WIDTH` and `DEPTH`;
  - ports: push, pop, flush, full, empty, head data;
  - storage is a register array with PTR_W+1-bit pointers, and full/empty are derived from the wrap bit.
- `instr_queue` contains the FSM, `next_pc`/`pend_pc` arithmetic, and the error flag.
- Constants `Q_S_REDIR`/`Q_S_RUN` and the entry width (`` `MAX_INSTR_WIDTH `` + 4 + `` `ADDRESS_WIDTH ``) are defined in `header.v`.

## Test plan
- Release reset, `i_pc_ready`=1 → `o_pc`=`RESET_PC`=0 is accepted; push three instructions with lengths 2, 5, 1 → decode sees PCs 0x0, 0x2, 0x7 in order.
- Hold `i_ready`=0 and push `DEPTH`+1 instructions → `o_fetch_ready`=0 after 4 pushes; the 5th is accepted only in the cycle after the first pop.
- With the queue holding 3 entries, assert `i_redirect_valid` with PC 0x100 while also pushing → `o_valid`=0 next cycle, `o_pc`=0x100, and the pushed instruction is lost; after the handshake, the first instruction out has PC 0x100.
- `next_pc`=0xFFFFFFFE, push a length-4 instruction → the next entry's PC is 0x00000002.
- Push with `i_fetch_len`=0 → no entry is written, `next_pc` is unchanged, and `o_len_err`=1 and stays set.
- Assert `reset`=0 between clock edges with the queue partly full → outputs take their reset values immediately and the first PC request after release is `RESET_PC`.

Source files
------------

// File: rtl/instr_queue_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instr_queue_pkg: shared widths, FSM encoding and entry layout. Rev 1.0
// ---------------------------------------------------------------------------
package instr_queue_pkg;

  localparam int ADDRESS_WIDTH   = 32;
  localparam int MAX_INSTR_WIDTH = 120;
  localparam int LEN_W           = 4;
  localparam int ENTRY_W         = MAX_INSTR_WIDTH + LEN_W + ADDRESS_WIDTH;

  localparam logic [0:0] Q_S_REDIR = 1'b0;
  localparam logic [0:0] Q_S_RUN   = 1'b1;

  typedef struct packed {
    logic [MAX_INSTR_WIDTH-1:0] instr;
    logic [LEN_W-1:0]           len;
    logic [ADDRESS_WIDTH-1:0]   pc;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instr_fifo: register-array FIFO with wrap-bit pointers and flush. Rev 1.0
// ---------------------------------------------------------------------------
module instr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Equal index bits with differing wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rdata = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instr_queue: fetch-to-decode instruction buffer that owns the fetch PC. Rev 1.0
// ---------------------------------------------------------------------------
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int                       DEPTH    = 4,
  parameter int                       PTR_W    = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       o_pc_valid,
  output logic [ADDRESS_WIDTH-1:0]   o_pc,
  input  logic                       i_pc_ready,
  input  logic                       i_fetch_valid,
  input  logic [MAX_INSTR_WIDTH-1:0] i_fetch_instr,
  input  logic [LEN_W-1:0]           i_fetch_len,
  output logic                       o_fetch_ready,
  input  logic                       i_redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]   i_redirect_pc,
  output logic                       o_valid,
  output logic [MAX_INSTR_WIDTH-1:0] o_instr,
  output logic [LEN_W-1:0]           o_instr_len,
  output logic [ADDRESS_WIDTH-1:0]   o_instr_pc,
  input  logic                       i_ready,
  output logic                       o_len_err
);

  logic [0:0]               state;
  logic [0:0]               state_next;
  logic [ADDRESS_WIDTH-1:0] pend_pc;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic                     len_err;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     accept;
  logic                     push;
  logic                     pop;
  entry_t                   push_entry;
  entry_t                   head_entry;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= Q_S_REDIR;
    else
      state <= state_next;
  end

  // Next-state logic; a redirect always wins over the PC handshake.
  always_comb begin
    state_next = state;
    if (i_redirect_valid)
      state_next = Q_S_REDIR;
    else if (state == Q_S_REDIR && i_pc_ready)
      state_next = Q_S_RUN;
  end

  // FSM outputs: while redirecting, fetch results are swallowed.
  always_comb begin
    o_pc_valid    = 1'b0;
    o_fetch_ready = !fifo_full;
    case (state)
      Q_S_REDIR: begin
        o_pc_valid    = 1'b1;
        o_fetch_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_pc   = pend_pc;
  assign accept = (state == Q_S_RUN) && i_fetch_valid && o_fetch_ready && !i_redirect_valid;
  assign push   = accept && (i_fetch_len != '0);
  assign pop    = !fifo_empty && i_ready && !i_redirect_valid;

  assign push_entry = '{instr: i_fetch_instr, len: i_fetch_len, pc: next_pc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_pc <= RESET_PC;
      next_pc <= '0;
      len_err <= 1'b0;
    end else begin
      if (i_redirect_valid)
        pend_pc <= i_redirect_pc;
      if (!i_redirect_valid) begin
        if (state == Q_S_REDIR && i_pc_ready)
          next_pc <= pend_pc;
        else if (push)
          next_pc <= next_pc + {{(ADDRESS_WIDTH-LEN_W){1'b0}}, i_fetch_len};
      end
      if (accept && i_fetch_len == '0)
        len_err <= 1'b1;
    end
  end

  instr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect_valid),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields read as zero when nothing is queued.
  assign o_valid     = !fifo_empty;
  assign o_instr     = o_valid ? head_entry.instr : '0;
  assign o_instr_len = o_valid ? head_entry.len   : '0;
  assign o_instr_pc  = o_valid ? head_entry.pc    : '0;
  assign o_len_err   = len_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_instr_queue: directed scenarios plus random traffic against a queue model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       o_pc_valid;
  logic [ADDRESS_WIDTH-1:0]   o_pc;
  logic                       i_pc_ready;
  logic                       i_fetch_valid;
  logic [MAX_INSTR_WIDTH-1:0] i_fetch_instr;
  logic [LEN_W-1:0]           i_fetch_len;
  logic                       o_fetch_ready;
  logic                       i_redirect_valid;
  logic [ADDRESS_WIDTH-1:0]   i_redirect_pc;
  logic                       o_valid;
  logic [MAX_INSTR_WIDTH-1:0] o_instr;
  logic [LEN_W-1:0]           o_instr_len;
  logic [ADDRESS_WIDTH-1:0]   o_instr_pc;
  logic                       i_ready;
  logic                       o_len_err;

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH), .PTR_W(2), .RESET_PC('0)) dut (
    .clk              (clk),
    .reset            (reset),
    .o_pc_valid       (o_pc_valid),
    .o_pc             (o_pc),
    .i_pc_ready       (i_pc_ready),
    .i_fetch_valid    (i_fetch_valid),
    .i_fetch_instr    (i_fetch_instr),
    .i_fetch_len      (i_fetch_len),
    .o_fetch_ready    (o_fetch_ready),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_valid          (o_valid),
    .o_instr          (o_instr),
    .o_instr_len      (o_instr_len),
    .o_instr_pc       (o_instr_pc),
    .i_ready          (i_ready),
    .o_len_err        (o_len_err)
  );

  typedef struct {
    logic [MAX_INSTR_WIDTH-1:0] instr;
    logic [LEN_W-1:0]           len;
    logic [ADDRESS_WIDTH-1:0]   pc;
  } ent_t;

  // Reference model: a plain queue plus the PC bookkeeping.
  ent_t                     mq[$];
  bit                       m_redir;
  logic [ADDRESS_WIDTH-1:0] m_pend;
  logic [ADDRESS_WIDTH-1:0] m_next;
  bit                       m_err;

  int tests = 0;
  int fails = 0;

  function automatic logic [MAX_INSTR_WIDTH-1:0] rand_instr();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[MAX_INSTR_WIDTH-1:0];
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_redir = 1'b1;
    m_pend  = '0;
    m_next  = '0;
    m_err   = 1'b0;
  endfunction

  task automatic idle();
    i_pc_ready       = 1'b0;
    i_fetch_valid    = 1'b0;
    i_fetch_instr    = '0;
    i_fetch_len      = '0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_ready          = 1'b0;
  endtask

  // Advance the model using the inputs currently driven, then clock the DUT.
  task automatic tick();
    bit   room;
    bit   do_pop;
    ent_t e;
    room = m_redir || (mq.size() < DEPTH);
    if (i_redirect_valid) begin
      mq.delete();
      m_pend  = i_redirect_pc;
      m_redir = 1'b1;
    end else if (m_redir) begin
      if (i_pc_ready) begin
        m_next  = m_pend;
        m_redir = 1'b0;
      end
    end else begin
      do_pop = (mq.size() > 0) && i_ready;
      if (do_pop) void'(mq.pop_front());
      if (i_fetch_valid && room) begin
        if (i_fetch_len == 0) begin
          m_err = 1'b1;
        end else begin
          e.instr = i_fetch_instr;
          e.len   = i_fetch_len;
          e.pc    = m_next;
          mq.push_back(e);
          m_next  = m_next + ADDRESS_WIDTH'(i_fetch_len);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({o_pc_valid, o_pc, o_fetch_ready, o_valid, o_instr_len, o_instr_pc, o_len_err} !==
        {1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got pcv=%b pc=%h fr=%b v=%b len=%h ipc=%h err=%b",
               o_pc_valid, o_pc, o_fetch_ready, o_valid, o_instr_len, o_instr_pc, o_len_err);
    end
    tests++;
    if (o_instr !== '0) begin
      fails++;
      $display("FAIL reset_instr: got %h expected 0", o_instr);
    end
    reset = 1'b1;
    m_reset();
  endtask

  task automatic test_basic();
    int               lens[3] = '{2, 5, 1};
    logic [31:0]      pcs[3]  = '{32'h0, 32'h2, 32'h7};
    i_pc_ready = 1'b1;
    tick();
    i_pc_ready = 1'b0;
    tests++;
    if (o_pc_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_handoff: o_pc_valid=%b expected 0", o_pc_valid);
    end
    for (int k = 0; k < 3; k++) begin
      i_fetch_valid = 1'b1;
      i_fetch_len   = LEN_W'(lens[k]);
      i_fetch_instr = rand_instr();
      tick();
      if (k == 0) begin
        tests++;
        if (o_valid !== 1'b1 || o_instr_pc !== 32'h0) begin
          fails++;
          $display("FAIL basic_latency: v=%b pc=%h expected v=1 pc=0", o_valid, o_instr_pc);
        end
      end
    end
    i_fetch_valid = 1'b0;
    tick();
    tests++;
    if (o_instr_pc !== 32'h0 || o_instr !== mq[0].instr) begin
      fails++;
      $display("FAIL basic_hold: pc=%h instr=%h expected pc=0 instr=%h", o_instr_pc, o_instr, mq[0].instr);
    end
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (o_valid !== 1'b1 || o_instr_pc !== pcs[k] || o_instr_len !== LEN_W'(lens[k]) ||
          o_instr !== mq[0].instr) begin
        fails++;
        $display("FAIL basic_pop%0d: v=%b pc=%h len=%h expected pc=%h len=%0d",
                 k, o_valid, o_instr_pc, o_instr_len, pcs[k], lens[k]);
      end
      tick();
    end
    i_ready = 1'b0;
    tests++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_empty: o_valid=%b expected 0", o_valid);
    end
  endtask

  task automatic test_full();
    i_ready       = 1'b0;
    i_fetch_valid = 1'b1;
    i_fetch_len   = 4'd3;
    for (int k = 0; k < DEPTH; k++) begin
      i_fetch_instr = rand_instr();
      tests++;
      if (o_fetch_ready !== 1'b1) begin
        fails++;
        $display("FAIL full_ready%0d: o_fetch_ready=%b expected 1", k, o_fetch_ready);
      end
      tick();
    end
    i_fetch_instr = rand_instr();
    tests++;
    if (o_fetch_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_stall: o_fetch_ready=%b expected 0", o_fetch_ready);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    tests++;
    if (o_fetch_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_after_pop: o_fetch_ready=%b expected 1", o_fetch_ready);
    end
    tick();
    i_fetch_valid = 1'b0;
    tests++;
    if (o_fetch_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_refill: o_fetch_ready=%b expected 0", o_fetch_ready);
    end
    // Queue now holds 0xB, 0xE, 0x11, 0x14
    i_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      tests++;
      if (o_valid !== 1'b1 || o_instr_pc !== 32'(11 + 3 * k) || o_instr !== mq[0].instr) begin
        fails++;
        $display("FAIL full_drain%0d: v=%b pc=%h expected pc=%h", k, o_valid, o_instr_pc, 32'(11 + 3 * k));
      end
      tick();
    end
    i_ready = 1'b0;
  endtask

  task automatic test_redirect();
    i_fetch_valid = 1'b1;
    i_fetch_len   = 4'd2;
    for (int k = 0; k < 3; k++) begin
      i_fetch_instr = rand_instr();
      tick();
    end
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h100;
    i_fetch_instr    = rand_instr();
    tick();
    i_fetch_valid = 1'b0;
    tests++;
    if (o_valid !== 1'b0 || o_pc_valid !== 1'b1 || o_pc !== 32'h100) begin
      fails++;
      $display("FAIL redir_flush: v=%b pcv=%b pc=%h expected v=0 pcv=1 pc=100", o_valid, o_pc_valid, o_pc);
    end
    // Second redirect collides with a PC handshake; the redirect must win.
    i_redirect_pc = 32'h300;
    i_pc_ready    = 1'b1;
    tick();
    tests++;
    if (o_pc_valid !== 1'b1 || o_pc !== 32'h300) begin
      fails++;
      $display("FAIL redir_replace: pcv=%b pc=%h expected pcv=1 pc=300", o_pc_valid, o_pc);
    end
    i_redirect_pc = 32'h100;
    i_pc_ready    = 1'b0;
    tick();
    i_redirect_valid = 1'b0;
    i_pc_ready       = 1'b1;
    tick();
    i_pc_ready = 1'b0;
    tests++;
    if (o_pc_valid !== 1'b0 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL redir_handoff: pcv=%b v=%b expected pcv=0 v=0", o_pc_valid, o_valid);
    end
    i_fetch_valid = 1'b1;
    i_fetch_len   = 4'd6;
    i_fetch_instr = rand_instr();
    tick();
    i_fetch_valid = 1'b0;
    tests++;
    if (o_valid !== 1'b1 || o_instr_pc !== 32'h100 || o_instr_len !== 4'd6) begin
      fails++;
      $display("FAIL redir_first: v=%b pc=%h len=%h expected v=1 pc=100 len=6", o_valid, o_instr_pc, o_instr_len);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_wrap();
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'hFFFF_FFFE;
    tick();
    i_redirect_valid = 1'b0;
    i_pc_ready       = 1'b1;
    tick();
    i_pc_ready    = 1'b0;
    i_fetch_valid = 1'b1;
    i_fetch_len   = 4'd4;
    i_fetch_instr = rand_instr();
    tick();
    i_fetch_len   = 4'd1;
    i_fetch_instr = rand_instr();
    tick();
    i_fetch_valid = 1'b0;
    tests++;
    if (o_instr_pc !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL wrap_first: pc=%h expected fffffffe", o_instr_pc);
    end
    i_ready = 1'b1;
    tick();
    tests++;
    if (o_valid !== 1'b1 || o_instr_pc !== 32'h2) begin
      fails++;
      $display("FAIL wrap_second: v=%b pc=%h expected v=1 pc=2", o_valid, o_instr_pc);
    end
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    tests++;
    if (o_len_err !== 1'b0) begin
      fails++;
      $display("FAIL zlen_pre: o_len_err=%b expected 0", o_len_err);
    end
    i_fetch_valid = 1'b1;
    i_fetch_len   = 4'd0;
    i_fetch_instr = rand_instr();
    tick();
    tests++;
    if (o_valid !== 1'b0 || o_len_err !== 1'b1) begin
      fails++;
      $display("FAIL zlen_drop: v=%b err=%b expected v=0 err=1", o_valid, o_len_err);
    end
    i_fetch_len   = 4'd3;
    i_fetch_instr = rand_instr();
    tick();
    i_fetch_valid = 1'b0;
    repeat (3) tick();
    tests++;
    if (o_instr_pc !== 32'h3 || o_len_err !== 1'b1) begin
      fails++;
      $display("FAIL zlen_next: pc=%h err=%b expected pc=3 err=1", o_instr_pc, o_len_err);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    i_fetch_valid = 1'b1;
    i_fetch_len   = 4'd5;
    repeat (2) begin
      i_fetch_instr = rand_instr();
      tick();
    end
    i_fetch_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    tests++;
    if ({o_pc_valid, o_pc, o_fetch_ready, o_valid, o_instr_len, o_instr_pc, o_len_err} !==
        {1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0} || o_instr !== '0) begin
      fails++;
      $display("FAIL async_reset: pcv=%b pc=%h fr=%b v=%b len=%h ipc=%h err=%b",
               o_pc_valid, o_pc, o_fetch_ready, o_valid, o_instr_len, o_instr_pc, o_len_err);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_reset();
    i_pc_ready = 1'b1;
    tests++;
    if (o_pc_valid !== 1'b1 || o_pc !== 32'h0) begin
      fails++;
      $display("FAIL async_first_pc: pcv=%b pc=%h expected pcv=1 pc=0", o_pc_valid, o_pc);
    end
    tick();
    i_pc_ready    = 1'b0;
    i_fetch_valid = 1'b1;
    i_fetch_len   = 4'd2;
    i_fetch_instr = rand_instr();
    tick();
    i_fetch_valid = 1'b0;
    tests++;
    if (o_valid !== 1'b1 || o_instr_pc !== 32'h0) begin
      fails++;
      $display("FAIL async_restart: v=%b pc=%h expected v=1 pc=0", o_valid, o_instr_pc);
    end
  endtask

  task automatic test_random();
    logic [191:0] exp_v;
    logic [191:0] got_v;
    int           bad = 0;
    for (int c = 0; c < 3000; c++) begin
      if (mq.size() > 0)
        exp_v = {m_redir, m_pend, (m_redir || mq.size() < DEPTH), 1'b1,
                 mq[0].instr, mq[0].len, mq[0].pc, m_err};
      else
        exp_v = {m_redir, m_pend, 1'b1, 1'b0, {MAX_INSTR_WIDTH{1'b0}}, 4'h0, 32'h0, m_err};
      got_v = {o_pc_valid, o_pc, o_fetch_ready, o_valid, o_instr, o_instr_len, o_instr_pc, o_len_err};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle%0d: got %h expected %h", c, got_v, exp_v);
      end
      i_redirect_valid = ($urandom_range(0, 99) < 3);
      i_redirect_pc    = $urandom();
      i_pc_ready       = $urandom_range(0, 1) == 1;
      i_fetch_valid    = ($urandom_range(0, 9) < 7);
      i_fetch_len      = ($urandom_range(0, 199) == 0) ? 4'd0 : LEN_W'($urandom_range(1, 15));
      i_fetch_instr    = rand_instr();
      i_ready          = ($urandom_range(0, 9) < 6);
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    m_reset();
    test_reset();
    test_basic();
    test_full();
    test_redirect();
    test_wrap();
    test_zero_len();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
